vegeta_output_collector: RTL
============================

// Module: vegeta_output_collector
// PURPOSE
// Drains the systolic array's skewed per-column outputs after each compute pass and deskews them into whole rows.
// Writes each row into the output L2 buffer and raises output_L2_loaded to the top-level VEGETA controller, which waits on it in WRITE_OUT.
// Sits directly downstream of the array/controller: output_valid (controller) starts a drain, output_L2_loaded ends the pass.
// PARAMETERS
// N               4                   array columns = output elements per row
// M_SCALED        4                   output rows per pass (>=1)
// DATA_W          32                  bits per output element
// TIMEOUT_CYCLES  2*(N+M_SCALED)+8    cycles without a completed row before the drain is aborted
// PORTS
// clk              in   1                     clock
// rst_n            in   1                     async active-low reset
// output_valid     in   1                     1-cycle pulse from controller: start drain
// array_out_valid  in   N                     per-column element valid
// array_out_data   in   N*DATA_W              column c at [c*DATA_W +: DATA_W]
// l2_wr_en         out  1                     L2 row write strobe
// l2_wr_addr       out  clog2(M_SCALED)       row index (width 1 if M_SCALED==1)
// l2_wr_data       out  N*DATA_W              deskewed row, same column packing
// output_L2_loaded out  1                     level: pass fully written (or aborted)
// busy             out  1                     high in DRAIN
// err_protocol     out  1                     sticky protocol violation
// err_timeout      out  1                     sticky drain abort
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, delay lines and counters cleared. Reset mid-drain drops partial rows; no L2 write follows.
// - Reset is async assert, sync deassert, as elsewhere in the accelerator.
// - States:
//   - IDLE: output_valid -> DRAIN (row_cnt=0, wd_cnt=0).
//   - DRAIN: row_cnt==M_SCALED after the last write -> DONE. wd_cnt==TIMEOUT_CYCLES -> DONE with err_timeout=1.
//   - DONE: output_L2_loaded=1 and held. output_valid -> DRAIN and clears output_L2_loaded the same cycle.
// - Array timing contract: output_valid sampled at t0. Column c presents row r at t0+1+r+c with array_out_valid[c]=1.
// - Deskew: column c passes through N-1-c register stages (column N-1 has 0 stages). Valid travels with its data.
// - Row r is aligned at t0+N+r.
// - Aligned row: all N delayed valids =1. Next cycle drive l2_wr_en=1, l2_wr_addr=row_cnt, l2_wr_data=row, then row_cnt++.
// - Last row is written at t0+N+M_SCALED. output_L2_loaded rises at t0+N+M_SCALED+1.
// - Partial alignment (some delayed valids set, not all): the row is not written, err_protocol=1, row_cnt unchanged.
// - Watchdog: wd_cnt increments each DRAIN cycle and resets to 0 on every row write.
// - Timeout still asserts output_L2_loaded, so the controller never hangs. err_timeout marks the L2 contents invalid.
// - output_valid while in DRAIN: ignored, err_protocol=1.
// - Any array_out_valid bit while in IDLE/DONE: data dropped, err_protocol=1.
// - Error flags clear only on reset.
// - Extra aligned rows after row_cnt==M_SCALED never write (wr_en gated by row_cnt<M_SCALED).
// - row_cnt width is clog2(M_SCALED+1); it never wraps.
// - No back-pressure: the L2 write port accepts one row per cycle unconditionally.
// STRUCTURE
// - vegeta_pkg: shared collector state enum (IDLE, DRAIN, DONE) and the vegeta_clog2 macro (guards NUM<=1).
// - Sub-module vegeta_skew_delay #(DEPTH, W): DEPTH-stage valid+data shift register with async clear.
//   - DEPTH==0 is combinational passthrough.
//   - One instance per column, generate loop, DEPTH=N-1-c.
// TESTING (N=4, M_SCALED=4, DATA_W=16 unless noted)
// - Nominal drain:
//   - pulse output_valid at t0; feed element = (r<<4)|c at t0+1+r+c.
//   - Expect 4 writes at t0+5..t0+8, addr 0..3, row r data {r3,r2,r1,r0}.
//   - output_L2_loaded=1 from t0+9 and held.
// - Back-to-back passes:
//   - after DONE, second output_valid clears output_L2_loaded next cycle.
//   - Second pass writes addr 0..3 again; no errors.
// - Missing column:
//   - suppress array_out_valid[2] for row 1.
//   - Expect err_protocol=1 and rows 0,2,3 written at addr 0,1,2.
//   - Then timeout after 24 idle cycles: err_timeout=1, output_L2_loaded=1.
// - Spurious traffic:
//   - array_out_valid=4'b0001 in IDLE -> no write, err_protocol=1.
//   - output_valid mid-DRAIN -> ignored, the pass completes normally.
// - Reset mid-drain: assert rst_n=0 after 2 rows written -> all outputs 0 immediately; no write after release; state IDLE.
// - Degenerate N=1, M_SCALED=1: one write at t0+2, addr 0; output_L2_loaded at t0+3.

Source files
------------

// File: rtl/vegeta_pkg.sv
// Shared definitions for the VEGETA output collection path: collector
// state encoding and a clog2 helper that never returns zero width.
package vegeta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } coll_state_e;

  // Width helper: a one-entry space still needs a 1-bit index.
  function automatic int vegeta_clog2(input int num);
    if (num <= 1) return 1;
    return $clog2(num);
  endfunction

endpackage

// File: rtl/vegeta_skew_delay.sv
// DEPTH-stage shift register carrying a valid bit alongside its data word.
// DEPTH==0 collapses to a wire so the last array column needs no special case.
module vegeta_skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    assign out_vld  = in_vld;
    assign out_data = in_data;
  end else begin : g_reg
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];

    // Next-state of the shift chain: stage 0 takes the input, others shift.
    always_comb begin
      vld_d[0]  = in_vld;
      data_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end

    // Shift registers, cleared so a reset never leaves a stale element behind.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];
  end

endmodule

// File: rtl/vegeta_output_collector.sv
// Drains the skewed column outputs of the systolic array after a compute
// pass, realigns them into rows and writes each row to the output L2 buffer.
// output_L2_loaded tells the top-level controller the pass is finished.
module vegeta_output_collector
  import vegeta_pkg::*;
#(
  parameter int N              = 4,
  parameter int M_SCALED       = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 2 * (N + M_SCALED) + 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              output_valid,
  input  logic [N-1:0]                      array_out_valid,
  input  logic [N*DATA_W-1:0]               array_out_data,
  output logic                              l2_wr_en,
  output logic [vegeta_clog2(M_SCALED)-1:0] l2_wr_addr,
  output logic [N*DATA_W-1:0]               l2_wr_data,
  output logic                              output_L2_loaded,
  output logic                              busy,
  output logic                              err_protocol,
  output logic                              err_timeout
);

  localparam int AW = vegeta_clog2(M_SCALED);
  localparam int CW = vegeta_clog2(M_SCALED + 1);
  localparam int WW = vegeta_clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]          rst_sync_q, rst_sync_d;
  logic                rst_ni;
  coll_state_e         state_q, state_d;
  logic [CW-1:0]       row_cnt_q, row_cnt_d;
  logic [WW-1:0]       wd_cnt_q, wd_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [N*DATA_W-1:0] wr_data_q, wr_data_d;
  logic                loaded_q, loaded_d;
  logic                busy_q, busy_d;
  logic                err_p_q, err_p_d;
  logic                err_t_q, err_t_d;

  logic [N-1:0]        in_vld;
  logic [N-1:0]        dly_vld;
  logic [N*DATA_W-1:0] dly_data;
  logic                row_aligned;
  logic                row_partial;

  // Reset synchronizer: assertion is immediate, release lands on a clock edge.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Reset synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_ni = rst_sync_q[1];

  // Only traffic that arrives during a drain enters the deskew lines.
  assign in_vld = (state_q == ST_DRAIN) ? array_out_valid : '0;

  // Column c arrives c cycles late, so it is delayed N-1-c cycles to line up.
  for (genvar c = 0; c < N; c++) begin : g_col
    vegeta_skew_delay #(
      .DEPTH(N - 1 - c),
      .W    (DATA_W)
    ) u_dly (
      .clk     (clk),
      .rst_n   (rst_ni),
      .in_vld  (in_vld[c]),
      .in_data (array_out_data[c*DATA_W +: DATA_W]),
      .out_vld (dly_vld[c]),
      .out_data(dly_data[c*DATA_W +: DATA_W])
    );
  end

  assign row_aligned = &dly_vld;
  assign row_partial = (|dly_vld) && !row_aligned;

  // Collector FSM next-state: row writes, watchdog and protocol checks.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    loaded_d  = loaded_q;
    err_p_d   = err_p_q;
    err_t_d   = err_t_q;
    unique case (state_q)
      ST_IDLE: begin
        if (output_valid) begin
          state_d   = ST_DRAIN;
          row_cnt_d = '0;
          wd_cnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (output_valid) err_p_d = 1'b1;
        if (row_cnt_q == CW'(M_SCALED)) begin
          state_d  = ST_DONE;
          loaded_d = 1'b1;
        end else if (wd_cnt_q == WW'(TIMEOUT_CYCLES)) begin
          // Abort still reports completion so the controller cannot hang.
          state_d  = ST_DONE;
          loaded_d = 1'b1;
          err_t_d  = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
          if (row_aligned) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_cnt_q[AW-1:0];
            wr_data_d = dly_data;
            row_cnt_d = row_cnt_q + CW'(1);
            wd_cnt_d  = '0;
          end else if (row_partial) begin
            err_p_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (output_valid) begin
          state_d   = ST_DRAIN;
          loaded_d  = 1'b0;
          row_cnt_d = '0;
          wd_cnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_DRAIN) && (|array_out_valid)) err_p_d = 1'b1;
    busy_d = (state_d == ST_DRAIN);
  end

  // Collector FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      wd_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_p_q   <= 1'b0;
      err_t_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      loaded_q  <= loaded_d;
      busy_q    <= busy_d;
      err_p_q   <= err_p_d;
      err_t_q   <= err_t_d;
    end
  end

  assign l2_wr_en         = wr_en_q;
  assign l2_wr_addr       = wr_addr_q;
  assign l2_wr_data       = wr_data_q;
  assign output_L2_loaded = loaded_q;
  assign busy             = busy_q;
  assign err_protocol     = err_p_q;
  assign err_timeout      = err_t_q;

endmodule
